dm_mc: RTL

Parametrised multi-cycle data memory for the processor datapath, the next generation of the single-cycle word-only data memory. A valid/ready request port accepts one access at a time. A fixed programmable wait latency models slow memory. Byte, halfword and word loads/stores are supported, with sign/zero extension, range checking and optional misalignment trapping. It sits behind the load/store stage of the multicycle and pipelined cores, which stall on `req_ready`/`resp_valid`.

---
 rtl/dm_mc.sv | 95 +++++++++
 1 files changed

// File: rtl/dm_mc.sv
// dm_mc: multi-cycle byte/half/word data memory with fixed wait latency (misalignment trap: DM_MISALIGN_TRAP_EN)
module dm_mc #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} st_t;
  st_t st;
  logic [CW-1:0] cnt;
  logic l_we, l_uns;
  logic [1:0] l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic f_we, f_uns, go, rng_err, mis, err;
  logic [1:0] f_size;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0] f_wdata, wd, word, nw, sh, ld;
  logic [IW-1:0] wi;
  logic [3:0] mask;
  // With LATENCY=1 the access point is the accept edge, so the live request is used before it is latched
  assign f_we    = st == IDLE ? req_we : l_we;
  assign f_uns   = st == IDLE ? req_unsigned : l_uns;
  assign f_size  = st == IDLE ? req_size : l_size;
  assign f_addr  = st == IDLE ? req_addr : l_addr;
  assign f_wdata = st == IDLE ? req_wdata : l_wdata;
  assign req_ready = st == IDLE;
  assign go = (st == IDLE && req_valid && LATENCY == 1) || (st == WAIT && cnt == '0);
  assign rng_err = 32'(f_addr[ADDR_W-1:2]) >= DEPTH;
  assign wi = f_addr[IW+1:2];
`ifdef DM_MISALIGN_TRAP_EN
  assign mis = (f_size == 2'b01 && f_addr[0]) || (f_size == 2'b10 && f_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign err = rng_err || f_size == 2'b11 || mis;
  assign word = mem[wi];
  assign wd = f_size == 2'b00 ? {4{f_wdata[7:0]}} : f_size == 2'b01 ? {2{f_wdata[15:0]}} : f_wdata;
  assign mask = f_size == 2'b00 ? 4'b0001 << f_addr[1:0] : f_size == 2'b01 ? (f_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign sh = word >> {(f_size[1] ? 2'b00 : f_size[0] ? {f_addr[1], 1'b0} : f_addr[1:0]), 3'b000};
  assign ld = f_size == 2'b00 ? {{24{~f_uns & sh[7]}}, sh[7:0]} : f_size == 2'b01 ? {{16{~f_uns & sh[15]}}, sh[15:0]} : sh;
  // Merge store lanes into the existing word so unselected bytes survive
  always_comb begin
    nw = word;
    for (int i = 0; i < 4; i++) nw[8*i +: 8] = mask[i] ? wd[8*i +: 8] : word[8*i +: 8];
  end
  // Request latch, wait counter, FSM and registered response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_uns <= 1'b0;
      l_size <= 2'b00;
      l_addr <= '0;
      l_wdata <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_valid <= go;
      resp_err <= go && err;
      resp_rdata <= go && !err && !f_we ? ld : '0;
      if (st == IDLE && req_valid) begin
        l_we <= req_we;
        l_uns <= req_unsigned;
        l_size <= req_size;
        l_addr <= req_addr;
        l_wdata <= req_wdata;
        cnt <= CW'(LATENCY - 1);
        st <= LATENCY == 1 ? RESP : WAIT;
      end else if (st == WAIT) begin
        if (cnt == '0) st <= RESP;
        else cnt <= cnt - 1'b1;
      end else if (st == RESP) st <= IDLE;
    end
  // Store commit at the access point; contents are not touched by reset
  always_ff @(posedge clk)
    if (rst_n && go && f_we && !err) mem[wi] <= nw;
endmodule
